// File: rtl/spi_note_sender.sv
// SPI master that shifts one frame of per-track note packets out MSB-first with chip-select framing.
// Define SPI_NOTE_SENDER_REPEAT_EN to resend the last frame after REPEAT_PERIOD idle cycles.
module spi_note_sender #(
  parameter int NUM_TRACKS    = 4,
  parameter int PACKET_SIZE   = 24,
  parameter int CLK_DIV       = 4,
`ifdef SPI_NOTE_SENDER_REPEAT_EN
  parameter int REPEAT_PERIOD = 2**24,
`endif
  parameter int CS_GAP        = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                frameValid,
  input  logic [NUM_TRACKS*PACKET_SIZE-1:0]   frameData,
  output logic                                frameReady,
  output logic                                frameDone,
  output logic                                chipSelect,
  output logic                                sck,
  output logic                                sdo
);

  localparam int TOTAL   = NUM_TRACKS * PACKET_SIZE;
  localparam int BIT_W   = $clog2(TOTAL + 1);
  localparam int DIV_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int DIV_W   = $clog2(DIV_MAX + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(TOTAL);

  // state | meaning
  // IDLE  | chipSelect low, waiting for a frame
  // SETUP | chipSelect high, first bit presented before the first sck edge
  // HIGH  | sck high, receiver samples sdo
  // LOW   | sck low, next bit presented
  // HOLD  | chipSelect held high after the last bit
  // GAP   | chipSelect low spacing before the next frame
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t               state;
  logic [TOTAL-1:0]     shiftReg;
  logic [DIV_W-1:0]     divCnt;
  logic [BIT_W-1:0]     bitCnt;
  logic                 startNow;
  logic [TOTAL-1:0]     startData;

`ifdef SPI_NOTE_SENDER_REPEAT_EN
  localparam int IDLE_W = $clog2(REPEAT_PERIOD);
  localparam logic [IDLE_W-1:0] REPEAT_LAST = IDLE_W'(REPEAT_PERIOD - 1);
  logic [IDLE_W-1:0]    idleCnt;
  logic [TOTAL-1:0]     lastFrame;
  logic                 haveFrame;
`endif

  // A fresh request always takes priority over an automatic resend.
  always_comb begin
    startNow  = (state == IDLE) && frameValid && frameReady;
    startData = frameData;
`ifdef SPI_NOTE_SENDER_REPEAT_EN
    if (!startNow && (state == IDLE) && frameReady && haveFrame && (idleCnt == REPEAT_LAST)) begin
      startNow  = 1'b1;
      startData = lastFrame;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      shiftReg   <= '0;
      divCnt     <= '0;
      bitCnt     <= '0;
      chipSelect <= 1'b0;
      sck        <= 1'b0;
      sdo        <= 1'b0;
      frameReady <= 1'b0;
      frameDone  <= 1'b0;
`ifdef SPI_NOTE_SENDER_REPEAT_EN
      idleCnt    <= '0;
      lastFrame  <= '0;
      haveFrame  <= 1'b0;
`endif
    end else begin
      frameDone <= 1'b0;
      case (state)
        IDLE: begin
          chipSelect <= 1'b0;
          sck        <= 1'b0;
          sdo        <= 1'b0;
          frameReady <= 1'b1;
          if (startNow) begin
            shiftReg   <= startData;
            sdo        <= startData[TOTAL-1];
            chipSelect <= 1'b1;
            frameReady <= 1'b0;
            divCnt     <= '0;
            bitCnt     <= '0;
            state      <= SETUP;
`ifdef SPI_NOTE_SENDER_REPEAT_EN
            idleCnt    <= '0;
            lastFrame  <= startData;
            haveFrame  <= 1'b1;
          end else begin
            idleCnt    <= idleCnt + 1'b1;
`endif
          end
        end
        SETUP: begin
          if (divCnt == DIV_LAST) begin
            divCnt <= '0;
            sck    <= 1'b1;
            bitCnt <= bitCnt + 1'b1;
            state  <= HIGH;
          end else begin
            divCnt <= divCnt + 1'b1;
          end
        end
        HIGH: begin
          if (divCnt == DIV_LAST) begin
            divCnt   <= '0;
            sck      <= 1'b0;
            shiftReg <= {shiftReg[TOTAL-2:0], 1'b0};
            sdo      <= shiftReg[TOTAL-2];
            state    <= LOW;
          end else begin
            divCnt <= divCnt + 1'b1;
          end
        end
        LOW: begin
          if (divCnt == DIV_LAST) begin
            divCnt <= '0;
            if (bitCnt == BITS_LAST) begin
              state <= HOLD;
            end else begin
              sck    <= 1'b1;
              bitCnt <= bitCnt + 1'b1;
              state  <= HIGH;
            end
          end else begin
            divCnt <= divCnt + 1'b1;
          end
        end
        HOLD: begin
          if (divCnt == DIV_LAST) begin
            divCnt     <= '0;
            chipSelect <= 1'b0;
            state      <= GAP;
          end else begin
            divCnt <= divCnt + 1'b1;
          end
        end
        GAP: begin
          if (divCnt == GAP_LAST) begin
            divCnt     <= '0;
            frameDone  <= 1'b1;
            frameReady <= 1'b1;
            state      <= IDLE;
          end else begin
            divCnt <= divCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_note_sender.sv
// Directed bench for spi_note_sender: reset, single frame timing/data, back-to-back,
// mid-frame reset and the idle resend behaviour (with or without SPI_NOTE_SENDER_REPEAT_EN).
module tb_spi_note_sender;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frameValid = 1'b0;
  logic [95:0] frameData = '0;
  logic        frameReady, frameDone, chipSelect, sck, sdo;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

`ifdef SPI_NOTE_SENDER_REPEAT_EN
  spi_note_sender #(.REPEAT_PERIOD(1000)) dut (
`else
  spi_note_sender dut (
`endif
    .clk(clk), .reset(reset), .frameValid(frameValid), .frameData(frameData),
    .frameReady(frameReady), .frameDone(frameDone), .chipSelect(chipSelect),
    .sck(sck), .sdo(sdo)
  );

  // Waits for frameReady, then presents data for exactly one accepting edge.
  task automatic start_frame(input logic [95:0] data, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (frameReady === 1'b1) ok = 1'b1;
    end
    frameData  = data;
    frameValid = 1'b1;
    @(posedge clk);
    #1 frameValid = 1'b0;
  endtask

  // Called just after the start edge; sample k is taken after start edge + k.
  task automatic capture_frame(output logic [95:0] got, output int edges, output int csCycles,
                               output int doneCycle, output int readyCycle, output int violations);
    logic prevSck, prevSdo;
    prevSck = 1'b0; prevSdo = 1'b0;
    got = '0; edges = 0; csCycles = 0; doneCycle = -1; readyCycle = -1; violations = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (chipSelect === 1'b1) csCycles++;
      if (sck === 1'b1 && prevSck === 1'b0) begin
        got = {got[94:0], sdo};
        edges++;
      end
      if (sck === 1'b1 && chipSelect !== 1'b1) violations++;
      if (k > 0 && sdo !== prevSdo && !(prevSck === 1'b1 && sck === 1'b0)) violations++;
      if (frameReady === 1'b1 && readyCycle < 0) readyCycle = k;
      prevSck = sck;
      prevSdo = sdo;
      if (frameDone === 1'b1) begin
        doneCycle = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b0;
    frameValid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    testsRun++;
    if ({chipSelect, sck, sdo, frameReady, frameDone} !== 5'b0) begin
      testsFailed++;
      $display("FAIL reset_outputs got=%b expected=00000", {chipSelect, sck, sdo, frameReady, frameDone});
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    testsRun++;
    if (frameReady !== 1'b1) begin
      testsFailed++;
      $display("FAIL reset_release_ready got=%b expected=1", frameReady);
    end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (chipSelect !== 1'b0 || sck !== 1'b0 || sdo !== 1'b0) bad++;
    end
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("FAIL idle_quiet got=%0d active samples expected=0", bad);
    end
  endtask

  task automatic test_single_frame();
    logic [95:0] data, got;
    int edges, csCycles, doneCycle, readyCycle, violations;
    bit ok;
    data = 96'h123456_ABCDEF_000000_FFFFFF;
    start_frame(data, ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("FAIL single_ready_wait got=timeout expected=frameReady");
    end
    capture_frame(got, edges, csCycles, doneCycle, readyCycle, violations);
    testsRun++;
    if (got !== data) begin
      testsFailed++;
      $display("FAIL single_data got=%h expected=%h", got, data);
    end
    testsRun++;
    if (edges != 96) begin
      testsFailed++;
      $display("FAIL single_edges got=%0d expected=96", edges);
    end
    testsRun++;
    if (csCycles != 776) begin
      testsFailed++;
      $display("FAIL single_cs_cycles got=%0d expected=776", csCycles);
    end
    testsRun++;
    if (doneCycle != 784) begin
      testsFailed++;
      $display("FAIL single_done_cycle got=%0d expected=784", doneCycle);
    end
    testsRun++;
    if (readyCycle != 784) begin
      testsFailed++;
      $display("FAIL single_ready_cycle got=%0d expected=784", readyCycle);
    end
    testsRun++;
    if (violations != 0) begin
      testsFailed++;
      $display("FAIL single_protocol got=%0d violations expected=0", violations);
    end
    @(negedge clk);
    testsRun++;
    if (frameDone !== 1'b0) begin
      testsFailed++;
      $display("FAIL single_done_pulse got=%b expected=0", frameDone);
    end
  endtask

  task automatic test_back_to_back();
    logic [95:0] a, b, gotA, gotB;
    logic prevCs, prevSck;
    int rises, falls, dones, fall1, rise2;
    bit ok;
    a = 96'h0F1E2D_3C4B5A_697887_96A5B4;
    b = 96'hFEDCBA_987654_321000_13579B;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (frameReady === 1'b1) ok = 1'b1;
    end
    frameData  = a;
    frameValid = 1'b1;
    @(posedge clk);
    #1 frameData = b;
    gotA = '0; gotB = '0;
    prevCs = 1'b1; prevSck = 1'b0;
    rises = 1; falls = 0; dones = 0; fall1 = -1; rise2 = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (chipSelect === 1'b1 && prevCs === 1'b0) begin
        rises++;
        if (rises == 2) begin
          rise2 = k;
          frameValid = 1'b0;
        end
      end
      if (chipSelect === 1'b0 && prevCs === 1'b1) begin
        falls++;
        if (falls == 1) fall1 = k;
      end
      if (sck === 1'b1 && prevSck === 1'b0) begin
        if (rises == 1) gotA = {gotA[94:0], sdo};
        else gotB = {gotB[94:0], sdo};
      end
      prevCs = chipSelect;
      prevSck = sck;
      if (frameDone === 1'b1) begin
        dones++;
        if (dones == 2) break;
      end
    end
    frameValid = 1'b0;
    testsRun++;
    if (!ok || rise2 - fall1 != 9 || rise2 < 0 || fall1 < 0) begin
      testsFailed++;
      $display("FAIL b2b_gap got=%0d (fall=%0d rise=%0d) expected=9", rise2 - fall1, fall1, rise2);
    end
    testsRun++;
    if (gotA !== a) begin
      testsFailed++;
      $display("FAIL b2b_first_data got=%h expected=%h", gotA, a);
    end
    testsRun++;
    if (gotB !== b) begin
      testsFailed++;
      $display("FAIL b2b_second_data got=%h expected=%h", gotB, b);
    end
  endtask

  task automatic test_reset_midframe();
    logic [95:0] c, d, got;
    logic prevSck;
    int edges, csCycles, doneCycle, readyCycle, violations, seen;
    bit ok;
    c = 96'hDEADBE_EF0123_456789_ABCDEF;
    d = 96'h5A5A5A_C3C3C3_0F0F0F_818181;
    start_frame(c, ok);
    prevSck = 1'b0;
    seen = 0;
    for (int k = 0; k < 1000 && seen < 40; k++) begin
      @(negedge clk);
      if (sck === 1'b1 && prevSck === 1'b0) seen++;
      prevSck = sck;
    end
    testsRun++;
    if (!ok || seen != 40) begin
      testsFailed++;
      $display("FAIL midreset_reach_bit40 got=%0d expected=40", seen);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    testsRun++;
    if ({chipSelect, sck, sdo, frameReady} !== 4'b0) begin
      testsFailed++;
      $display("FAIL midreset_outputs got=%b expected=0000", {chipSelect, sck, sdo, frameReady});
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    testsRun++;
    if (frameReady !== 1'b1) begin
      testsFailed++;
      $display("FAIL midreset_ready got=%b expected=1", frameReady);
    end
    start_frame(d, ok);
    capture_frame(got, edges, csCycles, doneCycle, readyCycle, violations);
    testsRun++;
    if (!ok || got !== d || edges != 96) begin
      testsFailed++;
      $display("FAIL midreset_new_frame got=%h edges=%0d expected=%h edges=96", got, edges, d);
    end
  endtask

  task automatic test_repeat();
    logic [95:0] e, got;
    int edges, csCycles, doneCycle, readyCycle, violations, n;
    bit ok;
    e = 96'h2468AC_13579B_FEDCBA_00FF00;
    start_frame(e, ok);
    capture_frame(got, edges, csCycles, doneCycle, readyCycle, violations);
    testsRun++;
    if (!ok || doneCycle != 784 || got !== e) begin
      testsFailed++;
      $display("FAIL repeat_first_frame got=%h done=%0d expected=%h done=784", got, doneCycle, e);
    end
`ifdef SPI_NOTE_SENDER_REPEAT_EN
    n = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk);
      #1;
      if (chipSelect === 1'b1) begin
        n = i;
        break;
      end
    end
    testsRun++;
    if (n != 1000) begin
      testsFailed++;
      $display("FAIL repeat_delay got=%0d expected=1000", n);
    end
    capture_frame(got, edges, csCycles, doneCycle, readyCycle, violations);
    testsRun++;
    if (got !== e || edges != 96 || doneCycle != 784) begin
      testsFailed++;
      $display("FAIL repeat_data got=%h edges=%0d done=%0d expected=%h edges=96 done=784",
               got, edges, doneCycle, e);
    end
`else
    n = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (chipSelect !== 1'b0 || sck !== 1'b0) n++;
    end
    testsRun++;
    if (n != 0) begin
      testsFailed++;
      $display("FAIL no_repeat got=%0d active samples expected=0", n);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_midframe();
    test_repeat();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
